// File: rtl/fifo_rst_sequencer.sv
// -----------------------------------------------------------------------------
// fifo_rst_sequencer
//
// Serialises FIFO reset requests from NREQ requesters. Each service runs
//   CLEAR (CLR_CYC) -> RESET (RST_CYC) -> PAUSE (PAUSE_CYC) -> ACK (1 cycle)
// while blocking writes, pulsing FIFO_RST in RESET, and finally strobing
// ACK[g] for the granted requester. After RST a power-up (init) sequence runs
// the same path without an ACK strobe and then raises INIT_DONE.
// Requesters are served round robin, starting one index above the last grant.
//
// Ports
//   CLK        in   1     clock, rising edge
//   RST        in   1     synchronous active-high reset
//   REQ        in   NREQ  level requests (captured into pending bits)
//   ACK        out  NREQ  one-cycle completion strobe to the granted requester
//   FIFO_RST   out  1     reset to the shared FIFOs
//   WR_BLOCK   out  1     FIFO write inhibit during a sequence
//   BUSY       out  1     state is not IDLE
//   INIT_DONE  out  1     power-up sequence has completed
//
// Configuration macro
//   FIFO_RST_SEQ_TMR_EN : when defined, every register is triplicated and the
//                         next value is computed from the 2-of-3 vote, so a
//                         single upset is masked and scrubbed on the next edge.
//
// Outputs are registered from the current state, so they trail the state
// register by one cycle.
// -----------------------------------------------------------------------------
module fifo_rst_sequencer #(
    parameter int NREQ      = 4,
    parameter int CLR_CYC   = 5,
    parameter int RST_CYC   = 10,
    parameter int PAUSE_CYC = 15
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    output logic [NREQ-1:0] ACK,
    output logic            FIFO_RST,
    output logic            WR_BLOCK,
    output logic            BUSY,
    output logic            INIT_DONE
);

    localparam int GW = $clog2(NREQ);

`ifdef FIFO_RST_SEQ_TMR_EN
    localparam int NCOPY = 3;
`else
    localparam int NCOPY = 1;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RESET = 3'd2,
        S_PAUSE = 3'd3,
        S_ACK   = 3'd4
    } state_t;

    // All state lives in one packed record so protection applies uniformly.
    typedef struct packed {
        state_t          state;
        logic [7:0]      cnt;
        logic            init;      // current sequence is the power-up one
        logic [NREQ-1:0] pend;
        logic [GW-1:0]   last;      // last granted index (also the ACK target)
        logic [NREQ-1:0] ack;
        logic            fifo_rst;
        logic            wr_block;
        logic            busy;
        logic            init_done;
    } regs_t;

    localparam regs_t RESET_VAL = '{
        state:     S_CLEAR,
        cnt:       8'(CLR_CYC - 1),
        init:      1'b1,
        pend:      '0,
        last:      GW'(NREQ - 1),
        ack:       '0,
        fifo_rst:  1'b1,
        wr_block:  1'b1,
        busy:      1'b1,
        init_done: 1'b0
    };

    regs_t regs_q [NCOPY];
    regs_t regs_v;
    regs_t regs_d;

    genvar gi;
    generate
        for (gi = 0; gi < NCOPY; gi++) begin : g_copy
            always_ff @(posedge CLK) begin
                if (RST) begin
                    regs_q[gi] <= RESET_VAL;
                end else begin
                    regs_q[gi] <= regs_d;
                end
            end
        end
    endgenerate

`ifdef FIFO_RST_SEQ_TMR_EN
    assign regs_v = (regs_q[0] & regs_q[1]) |
                    (regs_q[0] & regs_q[2]) |
                    (regs_q[1] & regs_q[2]);
`else
    assign regs_v = regs_q[0];
`endif

    logic [NREQ-1:0] pend_n;
    logic            found;
    logic [GW-1:0]   gsel;
    logic [GW-1:0]   idx;

    always_comb begin
        regs_d = regs_v;
        pend_n = regs_v.pend | REQ;
        found  = 1'b0;
        gsel   = regs_v.last;
        idx    = '0;

        // Round-robin search starting one above the last grant.
        for (int k = 1; k <= NREQ; k++) begin
            idx = GW'((int'(regs_v.last) + k) % NREQ);
            if (!found && regs_v.pend[idx]) begin
                found = 1'b1;
                gsel  = idx;
            end
        end

        case (regs_v.state)
            S_IDLE: begin
                if (found) begin
                    regs_d.state = S_CLEAR;
                    regs_d.cnt   = 8'(CLR_CYC - 1);
                    regs_d.last  = gsel;
                    pend_n[gsel] = 1'b0;    // grant clears even if REQ is still high
                end
            end
            S_CLEAR: begin
                if (regs_v.cnt == 8'd0) begin
                    regs_d.state = S_RESET;
                    regs_d.cnt   = 8'(RST_CYC - 1);
                end else begin
                    regs_d.cnt = regs_v.cnt - 8'd1;
                end
            end
            S_RESET: begin
                if (regs_v.cnt == 8'd0) begin
                    regs_d.state = S_PAUSE;
                    regs_d.cnt   = 8'(PAUSE_CYC - 1);
                end else begin
                    regs_d.cnt = regs_v.cnt - 8'd1;
                end
            end
            S_PAUSE: begin
                if (regs_v.cnt == 8'd0) begin
                    regs_d.state = S_ACK;
                end else begin
                    regs_d.cnt = regs_v.cnt - 8'd1;
                end
            end
            S_ACK: begin
                regs_d.init = 1'b0;
                // Go straight to the next service so BUSY never drops between them.
                if (found) begin
                    regs_d.state = S_CLEAR;
                    regs_d.cnt   = 8'(CLR_CYC - 1);
                    regs_d.last  = gsel;
                    pend_n[gsel] = 1'b0;
                end else begin
                    regs_d.state = S_IDLE;
                end
            end
            default: begin
                regs_d.state = S_IDLE;
            end
        endcase

        regs_d.pend = pend_n;

        // Registered outputs, decoded from the current state.
        regs_d.ack       = (regs_v.state == S_ACK && !regs_v.init) ?
                           ({{(NREQ-1){1'b0}}, 1'b1} << regs_v.last) : '0;
        regs_d.fifo_rst  = (regs_v.state == S_RESET);
        regs_d.wr_block  = (regs_v.state == S_CLEAR) || (regs_v.state == S_RESET) ||
                           (regs_v.state == S_PAUSE);
        regs_d.busy      = (regs_v.state != S_IDLE);
        regs_d.init_done = regs_v.init_done || (regs_v.state == S_ACK && regs_v.init);
    end

    assign ACK       = regs_v.ack;
    assign FIFO_RST  = regs_v.fifo_rst;
    assign WR_BLOCK  = regs_v.wr_block;
    assign BUSY      = regs_v.busy;
    assign INIT_DONE = regs_v.init_done;

endmodule

// File: tb/tb_fifo_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rst_sequencer
//
// Directed bench for fifo_rst_sequencer at default parameters. Each scenario
// task drives inputs after a rising edge and compares the output vector
// {ACK, FIFO_RST, WR_BLOCK, BUSY, INIT_DONE} one cycle at a time against
// hand-derived timing. Cycle n means "sampled just after edge E+n", where E is
// the edge that first samples the stimulus.
// -----------------------------------------------------------------------------
module tb_fifo_rst_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] ack;
    logic       fifo_rst;
    logic       wr_block;
    logic       busy;
    logic       init_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_rst_sequencer #(
        .NREQ      (4),
        .CLR_CYC   (5),
        .RST_CYC   (10),
        .PAUSE_CYC (15)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .REQ       (req),
        .ACK       (ack),
        .FIFO_RST  (fifo_rst),
        .WR_BLOCK  (wr_block),
        .BUSY      (busy),
        .INIT_DONE (init_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: reset for 3 edges, then let the init sequence finish.
    task automatic do_reset;
        req = 4'b0000;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (34) tick();
    endtask

    task automatic test_reset;
        logic [7:0] obs;
        logic [7:0] exp;
        rst = 1'b1;
        req = 4'b0000;
        repeat (3) tick();
        obs = {ack, fifo_rst, wr_block, busy, init_done};
        exp = 8'b0000_1110;
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL reset_hold got=%b exp=%b", obs, exp);
        end
        rst = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            obs = {ack, fifo_rst, wr_block, busy, init_done};
            exp = {4'b0000, (n >= 6 && n <= 15), (n <= 30), (n <= 31), (n >= 31)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL reset_init n=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_single;
        logic [7:0] obs;
        logic [7:0] exp;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) tick();
`ifdef FIFO_RST_SEQ_TMR_EN
            if (n == 20) dut.regs_q[1] = ~dut.regs_q[1];
`endif
            obs = {ack, fifo_rst, wr_block, busy, init_done};
            exp = {(n == 32) ? 4'b0100 : 4'b0000, (n >= 7 && n <= 16),
                   (n >= 2 && n <= 31), (n >= 2 && n <= 32), 1'b1};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single n=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        $display("test_single done");
    endtask

    task automatic test_multi;
        logic [7:0] obs;
        logic [7:0] exp;
        logic [3:0] ea;
        logic       fr;
        logic       wb;
        do_reset();
        req = 4'b1011;
        tick();
        req = 4'b0000;
        for (int n = 1; n <= 100; n++) begin
            tick();
            fr = 1'b0;
            wb = 1'b0;
            for (int s = 0; s < 3; s++) begin
                if (n >= 7 + 31 * s && n <= 16 + 31 * s) fr = 1'b1;
                if (n >= 2 + 31 * s && n <= 31 + 31 * s) wb = 1'b1;
            end
            ea = (n == 32) ? 4'b0001 : (n == 63) ? 4'b0010 : (n == 94) ? 4'b1000 : 4'b0000;
            obs = {ack, fifo_rst, wr_block, busy, init_done};
            exp = {ea, fr, wb, (n >= 2 && n <= 94), 1'b1};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL multi n=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        $display("test_multi done");
    endtask

    task automatic test_round_robin;
        logic [4:0] obs;
        logic [4:0] exp;
        logic [3:0] ea;
        do_reset();
        for (int n = 0; n <= 126; n++) begin
            req = {2'b00, 1'b1, (n == 0 || n % 31 == 10)};
            tick();
            ea = (n == 32) ? 4'b0001 : (n == 63) ? 4'b0010 :
                 (n == 94) ? 4'b0001 : (n == 125) ? 4'b0010 : 4'b0000;
            obs = {ack, busy};
            exp = {ea, (n >= 2)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL round_robin n=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        req = 4'b0000;
        $display("test_round_robin done");
    endtask

    task automatic test_init_pending;
        logic [7:0] obs;
        logic [7:0] exp;
        req = 4'b0000;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int m = 1; m <= 64; m++) begin
            req = (m == 5) ? 4'b1000 : 4'b0000;
            tick();
            obs = {ack, fifo_rst, wr_block, busy, init_done};
            exp = {(m == 62) ? 4'b1000 : 4'b0000,
                   ((m >= 6 && m <= 15) || (m >= 37 && m <= 46)),
                   ((m <= 30) || (m >= 32 && m <= 61)),
                   (m <= 62), (m >= 31)};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL init_pending m=%0d got=%b exp=%b", m, obs, exp);
            end
        end
        $display("test_init_pending done");
    endtask

    task automatic test_abort;
        logic [7:0] obs;
        logic [7:0] exp;
        int         m;
        do_reset();
        for (int n = 0; n <= 50; n++) begin
            req = (n == 0) ? 4'b0001 : (n == 3) ? 4'b0100 : 4'b0000;
            rst = (n == 10 || n == 11);
            tick();
            if (n < 10) begin
                exp = {4'b0000, (n >= 7), (n >= 2), (n >= 2), 1'b1};
            end else if (n < 12) begin
                exp = 8'b0000_1110;
            end else begin
                m   = n - 11;
                exp = {4'b0000, (m >= 6 && m <= 15), (m <= 30), (m <= 31), (m >= 31)};
            end
            obs = {ack, fifo_rst, wr_block, busy, init_done};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL abort n=%0d got=%b exp=%b", n, obs, exp);
            end
        end
        rst = 1'b0;
        $display("test_abort done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_round_robin();
        test_init_pending();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
